// File: rtl/jacobi_result_streamer_pkg.sv
// jacobi_result_streamer_pkg: shared Jacobi sizes and the streamer FSM state type (package common).
package common;
    localparam int JACOBI_N = 4;
    localparam int JACOBI_N_INPUT_DATA = JACOBI_N * JACOBI_N;
    localparam int JACOBI_ADDR_WIDTH = 8;
    localparam int JACOBI_OUTPUT_WORD_WIDTH = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_DONE} streamer_state_e;
endpackage

// File: rtl/jacobi_result_streamer_if.sv
// jacobi_result_streamer_if: controller handshake, RAM port B read path and output stream of the streamer.
interface jacobi_result_streamer_if
    import common::*;
#(
    parameter int DW = JACOBI_OUTPUT_WORD_WIDTH,
    parameter int AW = JACOBI_ADDR_WIDTH
);
    logic          start_i;
    logic          busy_o;
    logic          done_o;
    logic          ram_en_o;
    logic          ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_dout_i;
    logic [DW-1:0] out_dat_o;
    logic          out_vld_o;
    logic          out_rdy_i;
    modport master (
        input  start_i, ram_dout_i, out_rdy_i,
        output busy_o, done_o, ram_en_o, ram_we_o, ram_addr_o, out_dat_o, out_vld_o
    );
    modport slave (
        output start_i, ram_dout_i, out_rdy_i,
        input  busy_o, done_o, ram_en_o, ram_we_o, ram_addr_o, out_dat_o, out_vld_o
    );
endinterface

// File: rtl/jacobi_result_streamer_skid_fifo.sv
// jacobi_skid_fifo: 2-entry FIFO holding RAM read data; head is presented combinationally.
module jacobi_skid_fifo #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [1:0]    count
);
    logic [DW-1:0] mem [2];
    logic          wptr;
    logic          rptr;

    assign dout = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= ~wptr;
            end
            if (pop)
                rptr <= ~rptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/jacobi_result_streamer.sv
// jacobi_result_streamer: reads the result matrix from RAM port B and streams it out with valid/ready.
// Define JACOBI_STREAMER_DIAG_ONLY_EN to stream only the diagonal (eigenvalues).
module jacobi_result_streamer
    import common::*;
#(
    parameter int DW = JACOBI_OUTPUT_WORD_WIDTH,
    parameter int AW = JACOBI_ADDR_WIDTH,
    parameter int MATRIX_N = JACOBI_N
) (
    input logic clk,
    input logic rst,
    jacobi_result_streamer_if.master bus
);
`ifdef JACOBI_STREAMER_DIAG_ONLY_EN
    localparam int TOTAL = MATRIX_N;
`else
    localparam int TOTAL = MATRIX_N * MATRIX_N;
`endif
    localparam int CW = $clog2(MATRIX_N * MATRIX_N + 1);

    streamer_state_e state;
    logic [CW-1:0]   rd_cnt;
    logic [CW-1:0]   sent_cnt;
    logic            inflight;
    logic [1:0]      count;
    logic [2:0]      occ;
    logic            pop;
    logic            issue;
    logic [AW-1:0]   addr;

    // occupancy never exceeds 2, so a pop is what frees a slot when full
    assign occ   = {1'b0, count} + {2'b00, inflight};
    assign pop   = bus.out_vld_o && bus.out_rdy_i;
    assign issue = (state == ST_STREAM) && (occ < 3'd2 || pop);
`ifdef JACOBI_STREAMER_DIAG_ONLY_EN
    assign addr  = AW'(32'(rd_cnt) * (MATRIX_N + 1));
`else
    assign addr  = AW'(rd_cnt);
`endif

    assign bus.ram_en_o   = issue;
    assign bus.ram_we_o   = 1'b0;
    assign bus.ram_addr_o = issue ? addr : '0;
    assign bus.out_vld_o  = count != 2'd0;
    assign bus.busy_o     = state != ST_IDLE;
    assign bus.done_o     = state == ST_DONE;

    jacobi_skid_fifo #(.DW(DW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (bus.ram_dout_i),
        .dout  (bus.out_dat_o),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rd_cnt   <= '0;
            sent_cnt <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (pop)
                sent_cnt <= sent_cnt + CW'(1);
            case (state)
                ST_IDLE: if (bus.start_i) begin
                    state    <= ST_STREAM;
                    rd_cnt   <= '0;
                    sent_cnt <= '0;
                end
                ST_STREAM: if (issue) begin
                    rd_cnt <= rd_cnt + CW'(1);
                    if (rd_cnt == CW'(TOTAL - 1))
                        state <= ST_DRAIN;
                end
                ST_DRAIN: if (pop && sent_cnt == CW'(TOTAL - 1))
                    state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/jacobi_result_streamer.md
JACOBI_RESULT_STREAMER -- requirements
Module: jacobi_result_streamer

Interface
REQ-001 SHALL have parameter DW, default JACOBI_OUTPUT_WORD_WIDTH: data word width.
REQ-002 SHALL have parameter AW, default JACOBI_ADDR_WIDTH: RAM address width.
REQ-003 SHALL have parameter MATRIX_N, default JACOBI_N: matrix dimension (row-major MATRIX_N x MATRIX_N in RAM).
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start_i  in  1  single-cycle request from main controller (SEND_DATA entry).
REQ-007 SHALL have port busy_o  out  1  high from start acceptance until done.
REQ-008 SHALL have port done_o  out  1  one-cycle pulse after last word handed off.
REQ-009 SHALL have ports ram_en_o  out  1, ram_we_o  out  1, ram_addr_o  out  AW: read requests to RAM port B.
REQ-010 SHALL have port ram_dout_i  in  DW  RAM read data, valid exactly 1 cycle after ram_en_o.
REQ-011 SHALL have ports out_dat_o  out  DW, out_vld_o  out  1, out_rdy_i  in  1: stream to microcontroller; transfer when vld&rdy.

Function
REQ-012 SHALL implement FSM IDLE -> STREAM -> DRAIN -> DONE -> IDLE.
REQ-013 IDLE: start_i=1 SHALL move to STREAM, clear read/sent counters; busy_o=1 from next cycle.
REQ-014 STREAM: SHALL issue reads at addresses 0..MATRIX_N*MATRIX_N-1 in order; after last issue SHALL go to DRAIN.
REQ-015 DRAIN: when last word transferred on output, SHALL go to DONE; DONE asserts done_o for exactly one cycle, returns to IDLE, busy_o=0.
REQ-016 SHALL hold read data in a 2-entry FIFO; out_dat_o/out_vld_o driven from FIFO head only; out_vld_o = (count>0).
REQ-017 Read issue SHALL be permitted when count + in-flight < 2, or ==2 with a pop in the same cycle; never otherwise (no overflow, no lost RAM data).
REQ-018 With out_rdy_i held high: first out_vld_o 3 cycles after start_i cycle; then one word per cycle, no bubbles.
REQ-019 out_rdy_i low SHALL stall issuing once FIFO+in-flight full; out_dat_o SHALL stay stable while out_vld_o=1 and out_rdy_i=0.
REQ-020 Simultaneous push and pop SHALL keep count unchanged; order preserved.
REQ-021 start_i while busy_o=1 SHALL be ignored.
REQ-022 ram_we_o SHALL be constant 0; ram_addr_o SHALL be 0 when ram_en_o=0.
REQ-023 Counters SHALL be sized ceil(log2(MATRIX_N*MATRIX_N+1)); no wrap during a pass.

Reset
REQ-024 rst SHALL override all other inputs, including mid-stream: FSM=IDLE, FIFO emptied, in-flight cleared, counters 0.
REQ-025 Outputs after reset: busy_o=0, done_o=0, ram_en_o=0, ram_we_o=0, ram_addr_o=0, out_vld_o=0, out_dat_o=0.
REQ-026 RAM data returning the cycle after reset SHALL be discarded.

Configuration
REQ-027 Macro JACOBI_STREAMER_DIAG_ONLY_EN defined: SHALL read/send only diagonal addresses k*(MATRIX_N+1), k=0..MATRIX_N-1 (eigenvalues), MATRIX_N words per pass.
REQ-028 Macro undefined: SHALL send full matrix, MATRIX_N*MATRIX_N words, linear addresses.

Structure
REQ-029 JACOBI_N, JACOBI_N_INPUT_DATA, JACOBI_ADDR_WIDTH, JACOBI_OUTPUT_WORD_WIDTH and streamer FSM enum type SHALL live in package common.
REQ-030 The 2-entry FIFO SHALL be a sub-module jacobi_skid_fifo (push/pop/count, parameter DW).

Verification
REQ-031 N=4, RAM[i]=i+100, out_rdy_i=1, start pulse -> 16 words 100..115 on consecutive cycles, first 3 cycles after start, done_o one pulse after word 115.
REQ-032 Same, out_rdy_i toggling 1/0 each cycle -> same 16 words, in order, no duplicates, data stable while stalled.
REQ-033 out_rdy_i=0 for 20 cycles after start -> exactly 2 ram_en_o pulses, out_vld_o=1 with value 100 held.
REQ-034 rst asserted after 5 words -> next cycle all outputs at reset values; new start streams from 100 again.
REQ-035 start_i re-pulsed mid-stream -> ignored, total still 16 words, single done_o.
REQ-036 With JACOBI_STREAMER_DIAG_ONLY_EN, N=4 -> addresses 0,5,10,15; words 100,105,110,115; done_o after 4th.
